// File: rtl/spi_fl_seq_pkg.sv
// Shared types and constants for the SPI flash command sequencer.
// Op codes, SPI opcodes, master commtype encodings and FSM state types.
package spi_fl_seq_pkg;

   typedef enum logic [1:0] {
      OP_READ    = 2'd0,
      OP_PROGRAM = 2'd1,
      OP_ERASE   = 2'd2,
      OP_RDSTAT  = 2'd3
   } op_e;

   localparam logic [7:0] CMD_WREN = 8'h06;
   localparam logic [7:0] CMD_READ = 8'h03;
   localparam logic [7:0] CMD_PP   = 8'h02;
   localparam logic [7:0] CMD_SE   = 8'h20;
   localparam logic [7:0] CMD_RDSR = 8'h05;

   localparam logic [2:0] CT_CMD           = 3'b000;
   localparam logic [2:0] CT_CMD_ANS       = 3'b001;
   localparam logic [2:0] CT_CMD_ADDR_ANS  = 3'b010;
   localparam logic [2:0] CT_CMD_ADDR_DATA = 3'b100;
   localparam logic [2:0] CT_CMD_ADDR      = 3'b101;
   localparam logic [2:0] CT_IDLE          = 3'b111;

   localparam int WIP_BIT = 24;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] addr;
      logic [7:0]  cmd;
      logic [2:0]  commtype;
      logic [6:0]  nmiso;
   } xfer_t;

   localparam xfer_t XFER_RST = '{
      data: '0, addr: '0, cmd: '0,
      commtype: CT_IDLE, nmiso: '0
   };

   typedef enum logic [2:0] {
      S_IDLE, S_WREN, S_OP, S_POLL, S_GAP, S_RESP
   } seq_state_e;

   typedef enum logic [1:0] {
      HS_IDLE, HS_REQ, HS_WAIT
   } hs_state_e;

   function automatic xfer_t mk_xfer(
      input logic [7:0]  cmd,
      input logic [2:0]  ct,
      input logic [31:0] addr,
      input logic [31:0] data,
      input logic [6:0]  nmiso
   );
      xfer_t x;
      x.data     = data;
      x.addr     = addr;
      x.cmd      = cmd;
      x.commtype = ct;
      x.nmiso    = nmiso;
      return x;
   endfunction

endpackage

// File: rtl/spi_fl_xfer_hs.sv
// One SPI master transaction: validflag/tready handshake.
// Fields are frozen at start and held until the done pulse.
module spi_fl_xfer_hs
   import spi_fl_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  xfer_t       fields,
   output logic        done,
   output logic [31:0] rdata,
   output logic [31:0] m_data_in,
   output logic [31:0] m_address,
   output logic [7:0]  m_command,
   output logic [2:0]  m_commtype,
   output logic [6:0]  m_nmiso_bits,
   output logic        m_validflag,
   input  logic [31:0] m_data_out,
   input  logic        m_tready
);

   hs_state_e   state_q, state_d;
   xfer_t       fld_q, fld_d;
   logic        vf_q, vf_d;
   logic        done_q, done_d;
   logic [31:0] rdata_q, rdata_d;

   always_comb begin
      state_d = state_q;
      fld_d   = fld_q;
      vf_d    = vf_q;
      done_d  = 1'b0;
      rdata_d = rdata_q;
      unique case (state_q)
         HS_IDLE: begin
            if (start) begin
               fld_d   = fields;
               vf_d    = 1'b1;
               state_d = HS_REQ;
            end
         end
         HS_REQ: begin
            // master has latched the request once tready drops
            if (!m_tready) begin
               vf_d    = 1'b0;
               state_d = HS_WAIT;
            end
         end
         HS_WAIT: begin
            if (m_tready) begin
               done_d  = 1'b1;
               rdata_d = m_data_out;
               state_d = HS_IDLE;
            end
         end
         default: state_d = HS_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= HS_IDLE;
         fld_q   <= XFER_RST;
         vf_q    <= 1'b0;
         done_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         fld_q   <= fld_d;
         vf_q    <= vf_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
      end
   end

   assign done         = done_q;
   assign rdata        = rdata_q;
   assign m_data_in    = fld_q.data;
   assign m_address    = fld_q.addr;
   assign m_command    = fld_q.cmd;
   assign m_commtype   = fld_q.commtype;
   assign m_nmiso_bits = fld_q.nmiso;
   assign m_validflag  = vf_q;

endmodule

// File: rtl/spi_fl_seq.sv
// Flash request sequencer: WREN, op, then RDSR polling
// until write-in-progress clears or the poll budget runs out.
module spi_fl_seq
   import spi_fl_seq_pkg::*;
#(
   parameter int POLL_MAX = 1024,
   parameter int POLL_GAP = 16,
   parameter int ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [31:0]       m_data_in,
   output logic [31:0]       m_address,
   output logic [7:0]        m_command,
   output logic [2:0]        m_commtype,
   output logic [6:0]        m_nmiso_bits,
   output logic [3:0]        m_dummy_cycles,
   output logic              m_validflag,
   input  logic [31:0]       m_data_out,
   input  logic              m_tready
);

   localparam int CW = $clog2(POLL_MAX + 1);
   localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

   seq_state_e  state_q, state_d;
   op_e         op_q, op_d;
   logic [23:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        issued_q, issued_d;
   logic [CW-1:0] poll_q, poll_d, poll_inc;
   logic [GW-1:0] gap_q, gap_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        start, done;
   logic [31:0] xdata, addr24;
   logic [7:0]  status;
   logic        wip;
   xfer_t       fields;
   logic        unused_addr;

   assign unused_addr = ^req_addr[ADDR_W-1:24];
   assign addr24      = {8'h00, addr_q};
   assign status      = xdata[31:24];
   assign wip         = xdata[WIP_BIT];
   assign poll_inc    = poll_q + CW'(1);

   assign start = !issued_q &&
                  (state_q == S_WREN ||
                   state_q == S_OP ||
                   state_q == S_POLL);

   always_comb begin
      fields = mk_xfer(CMD_RDSR, CT_CMD_ANS, '0, '0, 7'd8);
      if (state_q == S_WREN) begin
         fields = mk_xfer(CMD_WREN, CT_CMD, '0, '0, '0);
      end else if (state_q == S_OP) begin
         unique case (op_q)
            OP_READ:
               fields = mk_xfer(CMD_READ, CT_CMD_ADDR_ANS,
                                addr24, '0, 7'd32);
            OP_PROGRAM:
               fields = mk_xfer(CMD_PP, CT_CMD_ADDR_DATA,
                                addr24, wdata_q, '0);
            OP_ERASE:
               fields = mk_xfer(CMD_SE, CT_CMD_ADDR,
                                addr24, '0, '0);
            default:
               fields = mk_xfer(CMD_RDSR, CT_CMD_ANS,
                                '0, '0, 7'd8);
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      issued_d = issued_q;
      poll_d   = poll_q;
      gap_d    = gap_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      if (start) issued_d = 1'b1;
      if (done)  issued_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d    = op_e'(req_op);
               addr_d  = req_addr[23:0];
               wdata_d = req_wdata;
               state_d = (req_op == OP_PROGRAM ||
                          req_op == OP_ERASE) ? S_WREN : S_OP;
            end
         end
         S_WREN: begin
            if (done) state_d = S_OP;
         end
         S_OP: begin
            if (done) begin
               unique case (op_q)
                  OP_READ: begin
                     rdata_d = xdata;
                     err_d   = 1'b0;
                     state_d = S_RESP;
                  end
                  OP_RDSTAT: begin
                     rdata_d = {24'h0, status};
                     err_d   = 1'b0;
                     state_d = S_RESP;
                  end
                  default: begin
                     poll_d  = '0;
                     state_d = S_POLL;
                  end
               endcase
            end
         end
         S_POLL: begin
            if (done) begin
               poll_d  = poll_inc;
               rdata_d = {24'h0, status};
               if (!wip) begin
                  err_d   = 1'b0;
                  state_d = S_RESP;
               end else if (int'(poll_inc) >= POLL_MAX) begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  gap_d   = '0;
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            // a zero gap still spends this one cycle here
            if (int'(gap_q) >= POLL_GAP - 1) state_d = S_POLL;
            else gap_d = gap_q + GW'(1);
         end
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= OP_READ;
         addr_q   <= '0;
         wdata_q  <= '0;
         issued_q <= 1'b0;
         poll_q   <= '0;
         gap_q    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         issued_q <= issued_d;
         poll_q   <= poll_d;
         gap_q    <= gap_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   spi_fl_xfer_hs u_hs (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .fields       (fields),
      .done         (done),
      .rdata        (xdata),
      .m_data_in    (m_data_in),
      .m_address    (m_address),
      .m_command    (m_command),
      .m_commtype   (m_commtype),
      .m_nmiso_bits (m_nmiso_bits),
      .m_validflag  (m_validflag),
      .m_data_out   (m_data_out),
      .m_tready     (m_tready)
   );

   assign req_ready      = (state_q == S_IDLE);
   assign rsp_valid      = (state_q == S_RESP);
   assign rsp_rdata      = rdata_q;
   assign rsp_err        = err_q;
   assign m_dummy_cycles = 4'd0;

endmodule

// File: tb/tb_spi_fl_seq.sv
// Bench for spi_fl_seq: behavioural SPI master model plus a
// request-level reference of the expected command sequence.
module tb_spi_fl_seq;

   localparam int PMAX = 4;
   localparam int PGAP = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = '0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] m_data_in;
   logic [31:0] m_address;
   logic [7:0]  m_command;
   logic [2:0]  m_commtype;
   logic [6:0]  m_nmiso_bits;
   logic [3:0]  m_dummy_cycles;
   logic        m_validflag;
   logic [31:0] m_data_out;
   logic        m_tready;

   spi_fl_seq #(.POLL_MAX(PMAX), .POLL_GAP(PGAP), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .m_data_in(m_data_in), .m_address(m_address),
      .m_command(m_command), .m_commtype(m_commtype),
      .m_nmiso_bits(m_nmiso_bits), .m_dummy_cycles(m_dummy_cycles),
      .m_validflag(m_validflag), .m_data_out(m_data_out),
      .m_tready(m_tready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct packed {
      logic [7:0]  cmd;
      logic [2:0]  ct;
      logic [31:0] addr;
      logic [31:0] data;
      logic [6:0]  nmiso;
      logic [3:0]  dummy;
   } txn_t;

   txn_t txq[$];
   txn_t expq[$];
   int   st_q[$];
   int   en_q[$];

   int checks = 0;
   int errors = 0;

   logic [31:0] rd_word;
   logic [7:0]  st_busy, st_done;
   int          wip_left = 0;
   int          field_err = 0;
   int          proto_err = 0;

   function automatic txn_t snap();
      txn_t t;
      t.cmd   = m_command;
      t.ct    = m_commtype;
      t.addr  = m_address;
      t.data  = m_data_in;
      t.nmiso = m_nmiso_bits;
      t.dummy = m_dummy_cycles;
      return t;
   endfunction

   function automatic txn_t mk(input logic [7:0] c, input logic [2:0] ct,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [6:0] n);
      txn_t t;
      t.cmd = c; t.ct = ct; t.addr = a; t.data = d;
      t.nmiso = n; t.dummy = 4'h0;
      return t;
   endfunction

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Behavioural SPI master: takes a request on validflag, drops
   // tready, works a few cycles, then returns data with tready high.
   initial begin : master
      txn_t cur;
      logic busy;
      int   lat;
      busy = 1'b0;
      lat = 0;
      cur = '0;
      m_tready = 1'b1;
      m_data_out = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy = 1'b0;
            m_tready = 1'b1;
         end else if (!busy) begin
            if (m_validflag) begin
               cur = snap();
               txq.push_back(cur);
               st_q.push_back(cyc);
               busy = 1'b1;
               m_tready = 1'b0;
               lat = $urandom_range(1, 4);
            end
         end else begin
            if (snap() !== cur) field_err++;
            if (m_validflag) proto_err++;
            if (lat > 0) begin
               lat--;
            end else begin
               if (cur.cmd == 8'h03) begin
                  m_data_out = rd_word;
               end else if (cur.cmd == 8'h05) begin
                  if (wip_left > 0) begin
                     m_data_out = {st_busy, 24'($urandom)};
                     wip_left--;
                  end else begin
                     m_data_out = {st_done, 24'($urandom)};
                  end
               end else begin
                  m_data_out = $urandom;
               end
               m_tready = 1'b1;
               en_q.push_back(cyc);
               busy = 1'b0;
            end
         end
      end
   end

   task automatic plan(input logic [31:0] rw, input int nw,
                       input logic [7:0] sb, input logic [7:0] sd);
      rd_word  = rw;
      wip_left = nw;
      st_busy  = sb | 8'h01;
      st_done  = sd & 8'hFE;
   endtask

   // Expected command list for one request, from the protocol rules.
   task automatic build_exp(input logic [1:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, input int nwip);
      logic [31:0] a;
      int np;
      a = {8'h00, addr[23:0]};
      expq.delete();
      if (op == 2'd1 || op == 2'd2)
         expq.push_back(mk(8'h06, 3'b000, 0, 0, 0));
      case (op)
         2'd0: expq.push_back(mk(8'h03, 3'b010, a, 0, 7'd32));
         2'd1: expq.push_back(mk(8'h02, 3'b100, a, wd, 0));
         2'd2: expq.push_back(mk(8'h20, 3'b101, a, 0, 0));
         default: expq.push_back(mk(8'h05, 3'b001, 0, 0, 7'd8));
      endcase
      if (op == 2'd1 || op == 2'd2) begin
         np = (nwip < PMAX) ? nwip + 1 : PMAX;
         repeat (np) expq.push_back(mk(8'h05, 3'b001, 0, 0, 7'd8));
      end
   endtask

   task automatic start_req(input logic [1:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, input bit hold);
      int n;
      @(negedge clk);
      req_op = op;
      req_addr = addr;
      req_wdata = wd;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", req_ready, 1'b1);
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag, input logic [1:0] op,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int nwip);
      int n;
      bit rdy_busy;
      logic [31:0] erd;
      logic eerr;
      int last;
      build_exp(op, addr, wd, nwip);
      eerr = 1'b0;
      case (op)
         2'd0: erd = rd_word;
         2'd3: erd = {24'h0, (nwip > 0) ? st_busy : st_done};
         default: begin
            erd  = {24'h0, st_done};
            eerr = (nwip >= PMAX);
         end
      endcase
      n = 0;
      rdy_busy = 1'b0;
      while (!rsp_valid && n < 5000) begin
         if (req_ready) rdy_busy = 1'b1;
         @(negedge clk);
         n++;
      end
      chk({tag, "_rsp_wait"}, rsp_valid, 1'b1);
      chk({tag, "_ready_busy"}, rdy_busy, 1'b0);
      chk({tag, "_err"}, rsp_err, eerr);
      if (!eerr) chk({tag, "_rdata"}, rsp_rdata, erd);
      chk({tag, "_ntxn"}, txq.size(), expq.size());
      for (int i = 0; i < expq.size() && i < txq.size(); i++) begin
         chk($sformatf("%s_cmd%0d", tag, i), txq[i].cmd, expq[i].cmd);
         chk($sformatf("%s_ct%0d", tag, i), txq[i].ct, expq[i].ct);
         chk($sformatf("%s_dmy%0d", tag, i), txq[i].dummy, 4'h0);
         if (expq[i].cmd inside {8'h03, 8'h02, 8'h20})
            chk($sformatf("%s_addr%0d", tag, i), txq[i].addr, expq[i].addr);
         if (expq[i].cmd == 8'h02)
            chk($sformatf("%s_data%0d", tag, i), txq[i].data, expq[i].data);
         if (expq[i].cmd inside {8'h03, 8'h05})
            chk($sformatf("%s_nmiso%0d", tag, i), txq[i].nmiso, expq[i].nmiso);
         if (i > 0 && expq[i].cmd == 8'h05 && expq[i-1].cmd == 8'h05 &&
             i < st_q.size())
            chk($sformatf("%s_gap%0d", tag, i),
                (st_q[i] - en_q[i-1]) > PGAP, 1'b1);
      end
      if (op == 2'd0 && en_q.size() > 0) begin
         last = en_q[en_q.size()-1];
         chk({tag, "_latency"}, cyc - last, 2);
      end
      txq.delete();
      st_q.delete();
      en_q.delete();
   endtask

   task automatic after_rsp(input string tag);
      logic [31:0] held;
      held = rsp_rdata;
      @(negedge clk);
      chk({tag, "_pulse"}, rsp_valid, 1'b0);
      chk({tag, "_hold"}, rsp_rdata, held);
      chk({tag, "_ready_back"}, req_ready, 1'b1);
   endtask

   initial begin : stim
      int n;
      logic [1:0] op;
      logic [31:0] addr, wd;
      int nw;

      repeat (2) @(negedge clk);
      chk("rst_ready", req_ready, 1'b1);
      chk("rst_rspv", rsp_valid, 1'b0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_err", rsp_err, 1'b0);
      chk("rst_vf", m_validflag, 1'b0);
      chk("rst_ct", m_commtype, 3'b111);
      chk("rst_cmd", m_command, 8'h00);
      chk("rst_addr", m_address, 32'h0);
      chk("rst_din", m_data_in, 32'h0);
      chk("rst_nmiso", m_nmiso_bits, 7'h0);
      chk("rst_dummy", m_dummy_cycles, 4'h0);
      rst = 1'b0;

      plan(32'hDEADBEEF, 0, 8'h00, 8'h00);
      start_req(2'd0, 32'h0000_1234, 32'h0, 1'b0);
      wait_rsp("read", 2'd0, 32'h0000_1234, 32'h0, 0);
      after_rsp("read");

      plan(32'h0, 3, 8'h03, 8'h00);
      start_req(2'd1, 32'h0000_0100, 32'hA5A5A5A5, 1'b0);
      wait_rsp("prog", 2'd1, 32'h0000_0100, 32'hA5A5A5A5, 3);
      after_rsp("prog");

      plan(32'h0, 100000, 8'h01, 8'h00);
      start_req(2'd2, 32'h0003_0000, 32'h0, 1'b0);
      wait_rsp("erase_to", 2'd2, 32'h0003_0000, 32'h0, 100000);
      after_rsp("erase_to");

      plan(32'h0, 0, 8'h00, 8'h02);
      start_req(2'd3, 32'h0, 32'h0, 1'b0);
      wait_rsp("rdstat", 2'd3, 32'h0, 32'h0, 0);
      after_rsp("rdstat");

      // request held high across a whole PROGRAM, op changed meanwhile
      plan(32'h13579BDF, 2, 8'h81, 8'h40);
      start_req(2'd1, 32'h0000_0200, 32'h0F0F0F0F, 1'b1);
      req_op = 2'd0;
      req_addr = 32'h0000_0ABC;
      wait_rsp("held_pp", 2'd1, 32'h0000_0200, 32'h0F0F0F0F, 2);
      after_rsp("held_pp");
      @(negedge clk);
      chk("held_accept", req_ready, 1'b0);
      req_valid = 1'b0;
      wait_rsp("held_rd", 2'd0, 32'h0000_0ABC, 32'h0, 0);
      after_rsp("held_rd");

      plan(32'h0, 100, 8'h03, 8'h00);
      start_req(2'd1, 32'h0000_0400, 32'h11223344, 1'b0);
      n = 0;
      while (!(m_validflag && m_command == 8'h02) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("pp_seen", m_validflag && m_command == 8'h02, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("midrst_vf", m_validflag, 1'b0);
      chk("midrst_ready", req_ready, 1'b1);
      chk("midrst_rspv", rsp_valid, 1'b0);
      chk("midrst_rdata", rsp_rdata, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      txq.delete();
      st_q.delete();
      en_q.delete();

      plan(32'hCAFEF00D, 0, 8'h00, 8'h00);
      start_req(2'd0, 32'hFF12_3456, 32'h0, 1'b0);
      wait_rsp("post_rst", 2'd0, 32'hFF12_3456, 32'h0, 0);
      after_rsp("post_rst");

      for (int i = 0; i < 10; i++) begin
         op   = 2'($urandom_range(0, 3));
         addr = $urandom;
         wd   = $urandom;
         nw   = $urandom_range(0, 5);
         plan($urandom, nw, 8'($urandom), 8'($urandom));
         start_req(op, addr, wd, 1'b0);
         wait_rsp($sformatf("rnd%0d", i), op, addr, wd, nw);
         after_rsp($sformatf("rnd%0d", i));
      end

      chk("field_stable", field_err, 0);
      chk("vf_protocol", proto_err, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
